// File: rtl/draw_pkg.sv
// Shared types and constants for the Mastermind VGA drawing path.
// Used by the rectangle scan generator and its slot mask counter.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_SLOT = 1'b1;

    localparam int DEF_XW = 9;
    localparam int DEF_YW = 8;
    localparam int CW     = 3;

endpackage

// File: rtl/slot_mask_counter.sv
// Phase / slot-index counters deciding which pixels of a row are drawn.
// A row is split into SLOT_W drawn columns followed by GAP_W skipped ones.
module slot_mask_counter
    import draw_pkg::*;
#(
    parameter int SW     = 3,
    parameter int SLOT_W = 4,
    parameter int GAP_W  = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          advance,
    input  logic          row_start,
    input  logic [SW-1:0] slots,
    input  logic          mode,
    output logic          drawable
);

    localparam int PERIOD = SLOT_W + GAP_W;
    localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [PW-1:0] r_phase;
    logic [SW-1:0] r_slot_idx;
    logic          w_period_end;
    logic          w_in_slot;

    assign w_period_end = (int'(r_phase) == PERIOD - 1);
    assign w_in_slot    = (int'(r_phase) < SLOT_W);

    // Slot index saturates so wide rows never wrap back into a drawn slot.
    always_ff @(posedge clock) begin
        if (reset || row_start) begin
            r_phase    <= '0;
            r_slot_idx <= '0;
        end else if (advance) begin
            if (w_period_end) begin
                r_phase <= '0;
                if (r_slot_idx != '1) begin
                    r_slot_idx <= r_slot_idx + SW'(1);
                end
            end else begin
                r_phase <= r_phase + PW'(1);
            end
        end
    end

    assign drawable = (mode == MODE_FILL) ||
                      (w_in_slot && (r_slot_idx < slots));

endmodule

// File: rtl/rect_raster_gen.sv
// Rectangle scan generator: walks a runtime-sized box in raster order.
// Emits absolute pixel coordinates with plot/ready backpressure.
module rect_raster_gen
    import draw_pkg::*;
#(
    parameter int XW     = DEF_XW,
    parameter int YW     = DEF_YW,
    parameter int SW     = 3,
    parameter int SLOT_W = 4,
    parameter int GAP_W  = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] rect_w,
    input  logic [YW-1:0] rect_h,
    input  logic          mode,
    input  logic [SW-1:0] slots,
    input  logic [CW-1:0] colour_in,
    input  logic          ready,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    state_t        r_state;
    logic [XW-1:0] r_x0;
    logic [YW-1:0] r_y0;
    logic [XW-1:0] r_w;
    logic [YW-1:0] r_h;
    logic          r_mode;
    logic [SW-1:0] r_slots;
    logic [CW-1:0] r_colour;
    logic [XW-1:0] r_cx;
    logic [YW-1:0] r_cy;

    logic w_accept;
    logic w_degen;
    logic w_drawable;
    logic w_adv;
    logic w_row_end;
    logic w_last;
    logic w_row_start;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_degen   = (rect_w == '0) || (rect_h == '0) ||
                       ((mode == MODE_SLOT) && (slots == '0));
    assign w_adv     = (r_state == SCAN) && (!w_drawable || ready);
    assign w_row_end = (r_cx == r_w - XW'(1));
    assign w_last    = w_row_end && (r_cy == r_h - YW'(1));

    assign w_row_start = w_accept || (w_adv && w_row_end);

    slot_mask_counter #(
        .SW     (SW),
        .SLOT_W (SLOT_W),
        .GAP_W  (GAP_W)
    ) u_mask (
        .clock     (clock),
        .reset     (reset),
        .advance   (w_adv),
        .row_start (w_row_start),
        .slots     (r_slots),
        .mode      (r_mode),
        .drawable  (w_drawable)
    );

    // Scan FSM: latch the request, step cx/cy, pulse done once at the end.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_x0     <= '0;
            r_y0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_mode   <= MODE_FILL;
            r_slots  <= '0;
            r_colour <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x0     <= x0;
                        r_y0     <= y0;
                        r_w      <= rect_w;
                        r_h      <= rect_h;
                        r_mode   <= mode;
                        r_slots  <= slots;
                        r_colour <= colour_in;
                        r_cx     <= '0;
                        r_cy     <= '0;
                        r_state  <= w_degen ? FINISH : SCAN;
                    end
                end
                SCAN: begin
                    if (w_adv) begin
                        if (w_last) begin
                            r_state <= FINISH;
                        end else if (w_row_end) begin
                            r_cx <= '0;
                            r_cy <= r_cy + YW'(1);
                        end else begin
                            r_cx <= r_cx + XW'(1);
                        end
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign x      = r_x0 + r_cx;
    assign y      = r_y0 + r_cy;
    assign colour = r_colour;
    assign plot   = (r_state == SCAN) && w_drawable;
    assign busy   = (r_state == SCAN);
    assign done   = (r_state == FINISH);

endmodule

// File: tb/tb_rect_raster_gen.sv
// Directed bench for rect_raster_gen: fill, backpressure, slots,
// degenerate sizes, coordinate wrap and reset/start control edges.
module tb_rect_raster_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] rect_w;
    logic [7:0] rect_h;
    logic       mode;
    logic [2:0] slots;
    logic [2:0] colour_in;
    logic       ready;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] qx[$];
    logic [7:0] qy[$];
    logic [8:0] ex[$];
    logic [7:0] ey[$];

    int pat[5] = '{1, 0, 1, 1, 0};

    always #5 clock = ~clock;

    rect_raster_gen dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .rect_w    (rect_w),
        .rect_h    (rect_h),
        .mode      (mode),
        .slots     (slots),
        .colour_in (colour_in),
        .ready     (ready),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [8:0] ax0, input logic [7:0] ay0,
                          input logic [8:0] aw, input logic [7:0] ah,
                          input logic am, input logic [2:0] as,
                          input logic [2:0] ac);
        @(negedge clock);
        x0 = ax0; y0 = ay0; rect_w = aw; rect_h = ah;
        mode = am; slots = as; colour_in = ac;
        start = 1'b1;
    endtask

    // Cycle k = k-th clock after the start edge; stops at done or budget.
    task automatic scan(input int budget, input bit bp, input int spulse,
                        output int nplot, output int dcyc);
        bit         hold;
        bit         r;
        logic [8:0] px;
        logic [7:0] py;
        qx.delete(); qy.delete();
        nplot = 0; dcyc = -1; hold = 0; px = '0; py = '0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock);
            start = (k == spulse);
            if (hold) begin
                chk("hold_xy", {15'd0, x, y}, {15'd0, px, py});
                chk("hold_plot", {31'd0, plot}, 32'd1);
            end
            if (done) begin
                dcyc = k;
                break;
            end
            r = bp ? (pat[(k - 1) % 5] != 0) : 1'b1;
            ready = r;
            if (plot && r) begin
                qx.push_back(x); qy.push_back(y); nplot++;
            end
            hold = plot && !r;
            px = x; py = y;
        end
        start = 1'b0;
        ready = 1'b1;
    endtask

    task automatic build_solid(input logic [8:0] ax0, input logic [7:0] ay0,
                               input int w, input int h);
        ex.delete(); ey.delete();
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                ex.push_back(9'(int'(ax0) + c));
                ey.push_back(8'(int'(ay0) + r));
            end
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, qx.size(), ex.size());
        for (int i = 0; i < qx.size() && i < ex.size(); i++)
            chk(tag, {15'd0, qx[i], qy[i]}, {15'd0, ex[i], ey[i]});
    endtask

    initial begin
        int np;
        int dc;
        bit seen;
        reset = 1'b1; start = 1'b0; ready = 1'b1;
        x0 = '0; y0 = '0; rect_w = '0; rect_h = '0;
        mode = 1'b0; slots = '0; colour_in = '0;
        repeat (3) @(negedge clock);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_colour", 32'(colour), 0);
        chk("rst_ctl", {29'd0, plot, busy, done}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ctl", {29'd0, plot, busy, done}, 0);

        // Solid 4x3 fill at (10,20), ready high
        launch(10, 20, 4, 3, 1'b0, 0, 5);
        scan(40, 0, 0, np, dc);
        chk("fill_nplot", np, 12);
        chk("fill_done_cyc", dc, 13);
        chk("fill_colour", 32'(colour), 5);
        chk("fill_done_busy", {30'd0, busy, plot}, 0);
        build_solid(10, 20, 4, 3);
        cmp_seq("fill_pix");
        @(negedge clock);
        chk("fill_after", {30'd0, busy, done}, 0);

        // Same scan under 1-0-1-1-0 backpressure
        launch(10, 20, 4, 3, 1'b0, 0, 2);
        scan(60, 1, 0, np, dc);
        chk("bp_nplot", np, 12);
        chk("bp_done_cyc", dc, 20);
        cmp_seq("bp_pix");

        // Slotted row: 3 slots of 4 px with 2 px gaps in a 22 px row
        launch(5, 30, 22, 4, 1'b1, 3, 1);
        scan(150, 0, 0, np, dc);
        chk("slot_nplot", np, 48);
        chk("slot_done_cyc", dc, 89);
        ex.delete(); ey.delete();
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 3; s++)
                for (int p = 0; p < 4; p++) begin
                    ex.push_back(9'(5 + s * 6 + p));
                    ey.push_back(8'(30 + r));
                end
        cmp_seq("slot_pix");

        // Degenerate sizes
        launch(3, 3, 0, 5, 1'b0, 0, 1);
        scan(10, 0, 0, np, dc);
        chk("w0_nplot", np, 0);
        chk("w0_done_cyc", dc, 1);
        launch(3, 3, 4, 2, 1'b1, 0, 1);
        scan(10, 0, 0, np, dc);
        chk("s0_nplot", np, 0);
        chk("s0_done_cyc", dc, 1);

        // X wrap past 511
        launch(510, 7, 4, 1, 1'b0, 0, 6);
        scan(20, 0, 0, np, dc);
        chk("wrap_done_cyc", dc, 5);
        ex.delete(); ey.delete();
        ex.push_back(9'd510); ex.push_back(9'd511);
        ex.push_back(9'd0);   ex.push_back(9'd1);
        repeat (4) ey.push_back(8'd7);
        cmp_seq("wrap_pix");

        // Reset at cx=2, cy=1
        launch(10, 20, 4, 3, 1'b0, 0, 4);
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        chk("mid_xy", {15'd0, x, y}, {15'd0, 9'd12, 8'd21});
        reset = 1'b1;
        @(negedge clock);
        chk("abort_ctl", {29'd0, plot, busy, done}, 0);
        chk("abort_x", 32'(x), 0);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clock);
            if (done || busy) seen = 1;
        end
        chk("abort_no_done", {31'd0, seen}, 0);

        // Fresh start completes normally
        launch(40, 50, 4, 3, 1'b0, 0, 3);
        scan(40, 0, 0, np, dc);
        chk("fresh_done_cyc", dc, 13);
        build_solid(40, 50, 4, 3);
        cmp_seq("fresh_pix");

        // Start pulse mid-scan is ignored
        launch(40, 50, 4, 3, 1'b0, 0, 3);
        scan(40, 0, 5, np, dc);
        chk("restart_done_cyc", dc, 13);
        cmp_seq("restart_pix");
        @(negedge clock);
        chk("restart_idle", {30'd0, busy, done}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
